// File: rtl/fp32_pkg.sv
// Shared FP32 constants, flag-bit positions and the divider state encoding.
package fp32_pkg;

   localparam int          FP32_BIAS    = 127;
   localparam logic [7:0]  FP32_EXP_MAX = 8'hFF;
   localparam logic [31:0] FP32_QNAN    = 32'h7FC0_0001;

   // Positions inside the 4-bit {invalid, div_by_zero, overflow, underflow} flag word
   localparam int FLAG_INVALID   = 3;
   localparam int FLAG_DIV_ZERO  = 2;
   localparam int FLAG_OVERFLOW  = 1;
   localparam int FLAG_UNDERFLOW = 0;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIVIDE = 2'd1,
      ROUND  = 2'd2,
      DONE   = 2'd3
   } div_state_t;

endpackage

// File: rtl/fp32_classify.sv
// Combinational unpack of one FP32 operand; subnormals are flushed to signed zero.
module fp32_classify
   import fp32_pkg::*;
(
   input  logic [31:0] i_op,
   output logic        o_sign,
   output logic [7:0]  o_exp,
   output logic [23:0] o_mant,
   output logic        o_is_nan,
   output logic        o_is_inf,
   output logic        o_is_zero
);

   logic w_exp_max;
   logic w_frac_zero;

   assign o_sign      = i_op[31];
   assign o_exp       = i_op[30:23];
   assign o_mant      = {1'b1, i_op[22:0]};
   assign w_exp_max   = (i_op[30:23] == FP32_EXP_MAX);
   assign w_frac_zero = (i_op[22:0] == 23'd0);
   assign o_is_nan    = w_exp_max & ~w_frac_zero;
   assign o_is_inf    = w_exp_max & w_frac_zero;
   assign o_is_zero   = (i_op[30:23] == 8'd0);

endmodule

// File: rtl/fp32_div.sv
// Iterative FP32 divider (restoring, one quotient bit per cycle) with valid/ready handshakes.
// Define FP32_DIV_RNE_EN for round-to-nearest-even; otherwise results truncate toward zero.
module fp32_div
   import fp32_pkg::*;
#(
   parameter int ITER = 27
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result,
   output logic [3:0]  flags
);

   div_state_t r_state, w_next_state;

   logic w_a_sign, w_a_nan, w_a_inf, w_a_zero;
   logic w_b_sign, w_b_nan, w_b_inf, w_b_zero;
   logic [7:0]  w_a_exp, w_b_exp;
   logic [23:0] w_a_mant, w_b_mant;

   logic               r_sign;
   logic signed [9:0]  r_exp;
   logic [24:0]        r_rem;
   logic [24:0]        r_div;
   logic [ITER-1:0]    r_q;
   logic [4:0]         r_count;
   logic               r_special;
   logic [31:0]        r_spec_result;
   logic [3:0]         r_spec_flags;
   logic [31:0]        r_result;
   logic [3:0]         r_flags;

   logic        w_sign;
   logic        w_special;
   logic [31:0] w_spec_result;
   logic [3:0]  w_spec_flags;

   logic [25:0] w_trial;
   logic        w_ge;
   logic [24:0] w_rem_sel;

   logic signed [9:0] w_norm_exp;
   logic signed [9:0] w_round_exp;
   logic [22:0]       w_mant;
   logic [23:0]       w_mant_sum;
   logic              w_round_up;
   logic [31:0]       w_round_result;
   logic [3:0]        w_round_flags;
`ifdef FP32_DIV_RNE_EN
   logic              w_guard;
   logic              w_sticky;
`endif

   fp32_classify u_cls_a (
      .i_op     (a),
      .o_sign   (w_a_sign),
      .o_exp    (w_a_exp),
      .o_mant   (w_a_mant),
      .o_is_nan (w_a_nan),
      .o_is_inf (w_a_inf),
      .o_is_zero(w_a_zero)
   );

   fp32_classify u_cls_b (
      .i_op     (b),
      .o_sign   (w_b_sign),
      .o_exp    (w_b_exp),
      .o_mant   (w_b_mant),
      .o_is_nan (w_b_nan),
      .o_is_inf (w_b_inf),
      .o_is_zero(w_b_zero)
   );

   assign w_sign = w_a_sign ^ w_b_sign;

   // Special operands are resolved at accept; the FSM still walks every state so latency is fixed
   always_comb begin
      w_special     = 1'b1;
      w_spec_result = 32'd0;
      w_spec_flags  = 4'd0;
      if (w_a_nan | w_b_nan) begin
         w_spec_result = FP32_QNAN;
      end else if ((w_a_zero & w_b_zero) | (w_a_inf & w_b_inf)) begin
         w_spec_result              = FP32_QNAN;
         w_spec_flags[FLAG_INVALID] = 1'b1;
      end else if (w_a_inf) begin
         w_spec_result = {w_sign, FP32_EXP_MAX, 23'd0};
      end else if (w_b_zero) begin
         w_spec_result               = {w_sign, FP32_EXP_MAX, 23'd0};
         w_spec_flags[FLAG_DIV_ZERO] = 1'b1;
      end else if (w_a_zero | w_b_inf) begin
         w_spec_result = {w_sign, 31'd0};
      end else begin
         w_special = 1'b0;
      end
   end

   // Restoring step: the remainder stays below twice the divisor, so 25 bits never overflow
   assign w_trial   = {1'b0, r_rem} - {1'b0, r_div};
   assign w_ge      = ~w_trial[25];
   assign w_rem_sel = w_ge ? w_trial[24:0] : r_rem;

   always_comb begin
      w_norm_exp = r_q[26] ? r_exp : (r_exp - 10'sd1);
      w_mant     = r_q[26] ? r_q[25:3] : r_q[24:2];
`ifdef FP32_DIV_RNE_EN
      w_guard    = r_q[26] ? r_q[2] : r_q[1];
      w_sticky   = (r_q[26] ? (|r_q[1:0]) : r_q[0]) | (r_rem != 25'd0);
      w_round_up = w_guard & (w_sticky | w_mant[0]);
`else
      w_round_up = 1'b0;
`endif
      w_mant_sum     = {1'b0, w_mant} + {23'd0, w_round_up};
      w_round_exp    = w_norm_exp + $signed({9'd0, w_mant_sum[23]});
      w_round_flags  = 4'd0;
      if (w_round_exp >= 10'sd255) begin
         w_round_result                = {r_sign, FP32_EXP_MAX, 23'd0};
         w_round_flags[FLAG_OVERFLOW]  = 1'b1;
      end else if (w_round_exp <= 10'sd0) begin
         w_round_result                = {r_sign, 31'd0};
         w_round_flags[FLAG_UNDERFLOW] = 1'b1;
      end else begin
         w_round_result = {r_sign, w_round_exp[7:0], w_mant_sum[22:0]};
      end
   end

   // NOTE: reset is synchronous here; every flop samples !rst_n only on the clock edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (in_valid)                 w_next_state = DIVIDE;
         DIVIDE:  if (r_count == 5'(ITER))      w_next_state = ROUND;
         ROUND:                                 w_next_state = DONE;
         DONE:    if (out_ready)                w_next_state = IDLE;
         default:                               w_next_state = IDLE;
      endcase
   end

   // NOTE: non-blocking assignments let every register read the pre-edge value of the others.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sign        <= 1'b0;
         r_exp         <= 10'sd0;
         r_rem         <= 25'd0;
         r_div         <= 25'd0;
         r_q           <= '0;
         r_count       <= 5'd0;
         r_special     <= 1'b0;
         r_spec_result <= 32'd0;
         r_spec_flags  <= 4'd0;
         r_result      <= 32'd0;
         r_flags       <= 4'd0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_sign        <= w_sign;
                  r_exp         <= $signed({2'b00, w_a_exp}) - $signed({2'b00, w_b_exp})
                                   + $signed(10'(FP32_BIAS));
                  r_rem         <= {1'b0, w_a_mant};
                  r_div         <= {1'b0, w_b_mant};
                  r_q           <= '0;
                  r_count       <= 5'd0;
                  r_special     <= w_special;
                  r_spec_result <= w_spec_result;
                  r_spec_flags  <= w_spec_flags;
               end
            end
            DIVIDE: begin
               if (r_count != 5'(ITER)) begin
                  r_rem   <= w_rem_sel << 1;
                  r_q     <= {r_q[ITER-2:0], w_ge};
                  r_count <= r_count + 5'd1;
               end
            end
            ROUND: begin
               r_result <= r_special ? r_spec_result : w_round_result;
               r_flags  <= r_special ? r_spec_flags  : w_round_flags;
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (r_state == IDLE) & rst_n;
   assign out_valid = (r_state == DONE);
   assign result    = r_result;
   assign flags     = r_flags;

endmodule
